// File: rtl/isa_pkg.sv
// Shared ISA constants for the instruction encoder and decoder.
// Holds field widths, field bit positions, immediate ranges and the
// format/state enums so both sides of the ISA agree on one layout.
package isa_pkg;

  // Architectural instruction word width; every field position below is within it.
  localparam int ISA_INSTR_W = 20;

  // Field widths.
  localparam int OPC_W  = 6;
  localparam int REG_W  = 2;
  localparam int SIMM_W = 10;
  localparam int BIMM_W = 12;
  localparam int JMP_W  = 9;

  // Field least-significant bit positions.
  localparam int OPC_LSB  = 14;
  localparam int RA_LSB   = 12;
  localparam int RB_LSB   = 10;
  localparam int RC_LSB   = 8;
  localparam int SIMM_LSB = 0;
  localparam int BIMM_LSB = 0;
  localparam int JMP_LSB  = 5;

  // Legal immediate ranges (two's complement for I/L, unsigned for J).
  localparam int SIMM_MIN = -(1 << (SIMM_W - 1));
  localparam int SIMM_MAX = (1 << (SIMM_W - 1)) - 1;
  localparam int BIMM_MIN = -(1 << (BIMM_W - 1));
  localparam int BIMM_MAX = (1 << (BIMM_W - 1)) - 1;
  localparam int JMP_MAX  = (1 << JMP_W) - 1;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_L = 2'd2,
    FMT_J = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer and immediate range checker.
// Ports: fmt/opcode/ra/rb/rc/imm fields in; packed word and range-error flag out.
// Latency 0; no flow control (pure function of its inputs).
module instr_pack
  import isa_pkg::*;
#(
  parameter int INSTR_W  = 20,
  parameter int IMM_IN_W = 16
) (
  input  logic [1:0]          fmt_i,
  input  logic [OPC_W-1:0]    opcode_i,
  input  logic [REG_W-1:0]    ra_i,
  input  logic [REG_W-1:0]    rb_i,
  input  logic [REG_W-1:0]    rc_i,
  input  logic [IMM_IN_W-1:0] imm_i,
  output logic [INSTR_W-1:0]  word_o,
  output logic                range_err_o
);

  // Sign-extended view of the immediate so all range checks are plain integer compares.
  int imm_int;

  always_comb begin
    imm_int = int'($signed(imm_i));
  end

  always_comb begin
    word_o      = '0;
    range_err_o = 1'b0;
    word_o[OPC_LSB +: OPC_W] = opcode_i;
    case (fmt_e'(fmt_i))
      FMT_R: begin
        word_o[RA_LSB +: REG_W] = ra_i;
        word_o[RB_LSB +: REG_W] = rb_i;
        word_o[RC_LSB +: REG_W] = rc_i;
      end
      FMT_I: begin
        word_o[RA_LSB +: REG_W]     = ra_i;
        word_o[RB_LSB +: REG_W]     = rb_i;
        word_o[SIMM_LSB +: SIMM_W]  = imm_i[SIMM_W-1:0];
        range_err_o = (imm_int < SIMM_MIN) || (imm_int > SIMM_MAX);
      end
      FMT_L: begin
        word_o[RA_LSB +: REG_W]     = ra_i;
        word_o[BIMM_LSB +: BIMM_W]  = imm_i[BIMM_W-1:0];
        range_err_o = (imm_int < BIMM_MIN) || (imm_int > BIMM_MAX);
      end
      FMT_J: begin
        // Jump target is an unsigned word address: anything negative is out of range.
        word_o[JMP_LSB +: JMP_W] = imm_i[JMP_W-1:0];
        range_err_o = (imm_int < 0) || (imm_int > JMP_MAX);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs instruction fields and writes them to consecutive imem words.
// Ports: start/base_addr session control, valid/ready field input, imem write port, done/err_code/word_count status.
// Latency 1 cycle from transfer to imem_we; in_ready is high only in LOAD (one instruction per cycle).
module instr_encoder
  import isa_pkg::*;
#(
  parameter int INSTR_W  = 20,
  parameter int ADDR_W   = 9,
  parameter int IMM_IN_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_fmt,
  input  logic [5:0]          in_opcode,
  input  logic [1:0]          in_ra,
  input  logic [1:0]          in_rb,
  input  logic [1:0]          in_rc,
  input  logic [IMM_IN_W-1:0] in_imm,
  input  logic                in_last,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [INSTR_W-1:0]  imem_wdata,
  output logic                done,
  output logic [1:0]          err_code,
  output logic [ADDR_W:0]     word_count
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                in_ready_q, in_ready_d;
  logic                done_q, done_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INSTR_W-1:0]  wdata_q, wdata_d;
  logic [1:0]          err_q, err_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;

  logic [INSTR_W-1:0]  packed_word;
  logic                range_err;
  logic                xfer;
  logic                ptr_at_end;

  instr_pack #(
    .INSTR_W  (INSTR_W),
    .IMM_IN_W (IMM_IN_W)
  ) u_pack (
    .fmt_i       (in_fmt),
    .opcode_i    (in_opcode),
    .ra_i        (in_ra),
    .rb_i        (in_rb),
    .rc_i        (in_rc),
    .imm_i       (in_imm),
    .word_o      (packed_word),
    .range_err_o (range_err)
  );

  // in_ready_q mirrors "state is LOAD", so a transfer can only happen in LOAD.
  assign xfer       = in_valid && in_ready_q;
  assign ptr_at_end = &ptr_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    in_ready_d = in_ready_q;
    done_d     = done_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_LOAD;
          ptr_d      = base_addr;
          cnt_d      = '0;
          err_d      = 2'b00;
          in_ready_d = 1'b1;
          done_d     = 1'b0;
        end
      end
      ST_LOAD: begin
        // start is deliberately ignored here: a session cannot be restarted mid-load.
        if (xfer) begin
          we_d     = 1'b1;
          addr_d   = ptr_q;
          wdata_d  = packed_word;
          cnt_d    = cnt_q + (ADDR_W+1)'(1);
          err_d[0] = err_q[0] | range_err;
          if (in_last) begin
            state_d    = ST_DONE;
            in_ready_d = 1'b0;
            done_d     = 1'b1;
          end else if (ptr_at_end) begin
            // Out of memory before the program ended: stop rather than wrap.
            state_d    = ST_DONE;
            in_ready_d = 1'b0;
            done_d     = 1'b1;
            err_d[1]   = 1'b1;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        in_ready_d = 1'b0;
        done_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 2'b00;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign done       = done_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign err_code   = err_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int INSTR_W  = 20;
  localparam int ADDR_W   = 9;
  localparam int IMM_IN_W = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_fmt;
  logic [5:0]          in_opcode;
  logic [1:0]          in_ra, in_rb, in_rc;
  logic [IMM_IN_W-1:0] in_imm;
  logic                in_last;
  logic                imem_we;
  logic [ADDR_W-1:0]   imem_addr;
  logic [INSTR_W-1:0]  imem_wdata;
  logic                done;
  logic [1:0]          err_code;
  logic [ADDR_W:0]     word_count;

  int total = 0;
  int bad   = 0;

  instr_encoder #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .IMM_IN_W(IMM_IN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .done(done), .err_code(err_code), .word_count(word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] f, input logic [5:0] op, input logic [1:0] a,
                       input logic [1:0] b, input logic [1:0] c, input logic [15:0] imm,
                       input logic last);
    in_valid  = 1'b1;
    in_fmt    = f;
    in_opcode = op;
    in_ra     = a;
    in_rb     = b;
    in_rc     = c;
    in_imm    = imm;
    in_last   = last;
  endtask

  task automatic begin_session(input logic [ADDR_W-1:0] base);
    in_valid  = 1'b0;
    start     = 1'b1;
    base_addr = base;
    tick();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_fmt = 2'd0; in_opcode = 6'd0; in_ra = 2'd0; in_rb = 2'd0; in_rc = 2'd0;
    in_imm = 16'd0; in_last = 1'b0;
    #23;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", imem_we); end
    total++; if (imem_addr !== 9'd0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    total++; if (imem_wdata !== 20'd0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", imem_wdata); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (err_code !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", err_code); end
    total++; if (word_count !== 10'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", word_count); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready got=%b exp=0", in_ready); end
  endtask

  task automatic test_basic_program();
    begin_session(9'h103);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", in_ready); end
    drive(2'd2, 6'h3F, 2'd2, 2'd0, 2'd0, 16'd10, 1'b0);
    tick();
    total++; if (imem_we !== 1'b1 || imem_addr !== 9'h103 || imem_wdata !== 20'hFE00A)
      begin bad++; $display("FAIL basic_w0 got we=%b a=%h d=%h exp we=1 a=103 d=FE00A", imem_we, imem_addr, imem_wdata); end
    total++; if (word_count !== 10'd1) begin bad++; $display("FAIL basic_cnt1 got=%0d exp=1", word_count); end
    drive(2'd0, 6'h00, 2'd0, 2'd0, 2'd1, 16'd0, 1'b0);
    tick();
    total++; if (imem_we !== 1'b1 || imem_addr !== 9'h104 || imem_wdata !== 20'h00100)
      begin bad++; $display("FAIL basic_w1 got we=%b a=%h d=%h exp we=1 a=104 d=00100", imem_we, imem_addr, imem_wdata); end
    drive(2'd1, 6'h10, 2'd1, 2'd1, 2'd0, 16'd1, 1'b1);
    tick();
    total++; if (imem_we !== 1'b1 || imem_addr !== 9'h105 || imem_wdata !== 20'h41401)
      begin bad++; $display("FAIL basic_w2 got we=%b a=%h d=%h exp we=1 a=105 d=41401", imem_we, imem_addr, imem_wdata); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", done); end
    total++; if (word_count !== 10'd3) begin bad++; $display("FAIL basic_cnt got=%0d exp=3", word_count); end
    total++; if (err_code !== 2'b00) begin bad++; $display("FAIL basic_err got=%b exp=00", err_code); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_fall got=%b exp=0", in_ready); end
    tick();
    total++; if (imem_we !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL basic_after got we=%b done=%b exp we=0 done=1", imem_we, done); end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    begin_session(9'h000);
    total++; if (done !== 1'b0 || word_count !== 10'd0) begin bad++; $display("FAIL b2b_restart got done=%b cnt=%0d exp 0 0", done, word_count); end
    drive(2'd1, 6'h26, 2'd1, 2'd2, 2'd3, 16'd3, 1'b0);
    tick();
    total++; if (imem_wdata !== 20'h99803 || imem_addr !== 9'h000) begin bad++; $display("FAIL b2b_i got a=%h d=%h exp a=000 d=99803", imem_addr, imem_wdata); end
    drive(2'd3, 6'h30, 2'd3, 2'd3, 2'd3, 16'h0103, 1'b0);
    tick();
    total++; if (imem_wdata !== 20'hC2060 || imem_addr !== 9'h001) begin bad++; $display("FAIL b2b_j got a=%h d=%h exp a=001 d=C2060", imem_addr, imem_wdata); end
    drive(2'd1, 6'h2C, 2'd3, 2'd0, 2'd1, 16'd0, 1'b1);
    tick();
    total++; if (imem_we !== 1'b1 || imem_wdata !== 20'hB3000 || imem_addr !== 9'h002) begin bad++; $display("FAIL b2b_i2 got we=%b a=%h d=%h exp we=1 a=002 d=B3000", imem_we, imem_addr, imem_wdata); end
    total++; if (err_code !== 2'b00 || word_count !== 10'd3) begin bad++; $display("FAIL b2b_status got err=%b cnt=%0d exp 00 3", err_code, word_count); end
    in_valid = 1'b0;
  endtask

  task automatic test_range();
    begin_session(9'h020);
    drive(2'd1, 6'h00, 2'd0, 2'd0, 2'd0, 16'd512, 1'b1);
    tick();
    total++; if (imem_wdata !== 20'h00200) begin bad++; $display("FAIL rng_i_word got=%h exp=00200", imem_wdata); end
    total++; if (err_code !== 2'b01) begin bad++; $display("FAIL rng_i_err got=%b exp=01", err_code); end
    in_valid = 1'b0;
    tick(); tick();
    total++; if (err_code !== 2'b01) begin bad++; $display("FAIL rng_sticky got=%b exp=01", err_code); end
    begin_session(9'h030);
    total++; if (err_code !== 2'b00) begin bad++; $display("FAIL rng_clear got=%b exp=00", err_code); end
    drive(2'd3, 6'h00, 2'd0, 2'd0, 2'd0, 16'hFFFF, 1'b1);
    tick();
    total++; if (imem_wdata !== 20'h03FE0 || err_code !== 2'b01) begin bad++; $display("FAIL rng_j_neg got d=%h err=%b exp d=03FE0 err=01", imem_wdata, err_code); end
    in_valid = 1'b0;
    // In-range extremes must not flag.
    begin_session(9'h040);
    drive(2'd2, 6'h00, 2'd0, 2'd0, 2'd0, 16'hF800, 1'b0);
    tick();
    total++; if (imem_wdata !== 20'h00800 || err_code !== 2'b00) begin bad++; $display("FAIL rng_l_min got d=%h err=%b exp d=00800 err=00", imem_wdata, err_code); end
    drive(2'd2, 6'h00, 2'd0, 2'd0, 2'd0, 16'd2047, 1'b0);
    tick();
    total++; if (imem_wdata !== 20'h007FF || err_code !== 2'b00) begin bad++; $display("FAIL rng_l_max got d=%h err=%b exp d=007FF err=00", imem_wdata, err_code); end
    drive(2'd1, 6'h00, 2'd0, 2'd0, 2'd0, 16'hFE00, 1'b0);
    tick();
    total++; if (imem_wdata !== 20'h00200 || err_code !== 2'b00) begin bad++; $display("FAIL rng_i_min got d=%h err=%b exp d=00200 err=00", imem_wdata, err_code); end
    drive(2'd3, 6'h00, 2'd0, 2'd0, 2'd0, 16'd511, 1'b0);
    tick();
    total++; if (imem_wdata !== 20'h03FE0 || err_code !== 2'b00) begin bad++; $display("FAIL rng_j_max got d=%h err=%b exp d=03FE0 err=00", imem_wdata, err_code); end
    drive(2'd2, 6'h00, 2'd0, 2'd0, 2'd0, 16'd2048, 1'b1);
    tick();
    total++; if (imem_wdata !== 20'h00800 || err_code !== 2'b01) begin bad++; $display("FAIL rng_l_over got d=%h err=%b exp d=00800 err=01", imem_wdata, err_code); end
    in_valid = 1'b0;
  endtask

  task automatic test_truncate();
    begin_session(9'd510);
    drive(2'd0, 6'h01, 2'd1, 2'd2, 2'd3, 16'd0, 1'b0);
    tick();
    total++; if (imem_we !== 1'b1 || imem_addr !== 9'd510 || word_count !== 10'd1) begin bad++; $display("FAIL trunc_w0 got we=%b a=%0d cnt=%0d exp we=1 a=510 cnt=1", imem_we, imem_addr, word_count); end
    tick();
    total++; if (imem_we !== 1'b1 || imem_addr !== 9'd511) begin bad++; $display("FAIL trunc_w1 got we=%b a=%0d exp we=1 a=511", imem_we, imem_addr); end
    total++; if (done !== 1'b1 || err_code !== 2'b10 || word_count !== 10'd2) begin bad++; $display("FAIL trunc_status got done=%b err=%b cnt=%0d exp 1 10 2", done, err_code, word_count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL trunc_ready got=%b exp=0", in_ready); end
    tick();
    total++; if (imem_we !== 1'b0 || imem_addr !== 9'd511 || word_count !== 10'd2) begin bad++; $display("FAIL trunc_nowrap got we=%b a=%0d cnt=%0d exp we=0 a=511 cnt=2", imem_we, imem_addr, word_count); end
    in_valid = 1'b0;
  endtask

  task automatic test_valid_gaps();
    begin_session(9'h040);
    drive(2'd0, 6'h02, 2'd0, 2'd0, 2'd0, 16'd0, 1'b0);
    tick();
    total++; if (imem_we !== 1'b1 || imem_addr !== 9'h040) begin bad++; $display("FAIL gap_w0 got we=%b a=%h exp we=1 a=040", imem_we, imem_addr); end
    // Bubble cycle; a start pulse here must not restart the session.
    in_valid  = 1'b0;
    start     = 1'b1;
    base_addr = 9'h1F0;
    tick();
    start = 1'b0;
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL gap_bubble got we=%b exp=0", imem_we); end
    drive(2'd0, 6'h03, 2'd0, 2'd0, 2'd0, 16'd0, 1'b1);
    tick();
    total++; if (imem_we !== 1'b1 || imem_addr !== 9'h041 || imem_wdata !== 20'h0C000) begin bad++; $display("FAIL gap_w1 got we=%b a=%h d=%h exp we=1 a=041 d=0C000", imem_we, imem_addr, imem_wdata); end
    total++; if (word_count !== 10'd2 || done !== 1'b1) begin bad++; $display("FAIL gap_status got cnt=%0d done=%b exp 2 1", word_count, done); end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    begin_session(9'h080);
    drive(2'd0, 6'h05, 2'd0, 2'd0, 2'd0, 16'd0, 1'b0);
    tick();
    total++; if (imem_we !== 1'b1) begin bad++; $display("FAIL arst_pre got we=%b exp=1", imem_we); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (imem_we !== 1'b0 || imem_addr !== 9'd0 || imem_wdata !== 20'd0) begin bad++; $display("FAIL arst_async got we=%b a=%h d=%h exp 0 0 0", imem_we, imem_addr, imem_wdata); end
    total++; if (in_ready !== 1'b0 || word_count !== 10'd0) begin bad++; $display("FAIL arst_state got rdy=%b cnt=%0d exp 0 0", in_ready, word_count); end
    #2;
    rst_n = 1'b1;
    tick();
    total++; if (imem_we !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || err_code !== 2'b00 || word_count !== 10'd0)
      begin bad++; $display("FAIL arst_idle got we=%b rdy=%b done=%b err=%b cnt=%0d exp all 0", imem_we, in_ready, done, err_code, word_count); end
    begin_session(9'h010);
    drive(2'd0, 6'h00, 2'd0, 2'd0, 2'd2, 16'd0, 1'b1);
    tick();
    total++; if (imem_we !== 1'b1 || imem_addr !== 9'h010 || imem_wdata !== 20'h00200 || done !== 1'b1 || word_count !== 10'd1)
      begin bad++; $display("FAIL arst_restart got we=%b a=%h d=%h done=%b cnt=%0d exp 1 010 00200 1 1", imem_we, imem_addr, imem_wdata, done, word_count); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_program();
    test_back_to_back();
    test_range();
    test_truncate();
    test_valid_gaps();
    test_async_reset();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs instruction fields into 20-bit instruction words and streams them into instruction memory at consecutive word addresses. It is the program-loading counterpart of the instruction decoder: `instr_encoder` packs the fields that the decoder unpacks. It sits between a host-side program source (test bench, debug port or boot sequencer) and the instruction memory write port. It also range-checks immediates and flags any program truncated at the end of memory.

## Interface
- `INSTR_W`, default 20: instruction word width.
- `ADDR_W`, default 9: instruction memory word-address width. Memory depth is 2^ADDR_W.
- `IMM_IN_W`, default 16: width of the signed immediate input.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load session at `base_addr`.
- `base_addr`  in  ADDR_W  first word address; sampled on an accepted `start`.
- `in_valid`  in  1  instruction fields are valid.
- `in_ready`  out  1  encoder accepts fields this cycle.
- `in_fmt`  in  2  format: 0=R (3 reg), 1=I (2 reg + 10-bit imm), 2=L (1 reg + 12-bit imm), 3=J (9-bit jump address).
- `in_opcode`  in  6  opcode.
- `in_ra`, `in_rb`, `in_rc`  in  2 each  rAlpha, rBeta, rGamma.
- `in_imm`  in  IMM_IN_W  signed immediate/offset. For J it is an unsigned word address.
- `in_last`  in  1  this instruction is the final one of the program.
- `imem_we`  out  1  write strobe.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  INSTR_W  encoded word.
- `done`  out  1  session finished; held high until the next `start`.
- `err_code`  out  2  sticky flags. bit0 = field out of range; bit1 = truncated at end of memory.
- `word_count`  out  ADDR_W+1  words written this session.

## Operation
- Word layout:
  - opcode at [19:14].
  - R: ra [13:12], rb [11:10], rc [9:8], [7:0]=0.
  - I: ra [13:12], rb [11:10], imm[9:0].
  - L: ra [13:12], imm[11:0].
  - J: addr [13:5], [4:0]=0.
- Unused fields are forced to zero; unused inputs are ignored.
- FSM has three states: IDLE, LOAD, DONE.
- IDLE:
  - `in_ready`=0.
  - `start` → LOAD; pointer=`base_addr`, `word_count`=0, `err_code`=0.
- LOAD:
  - `in_ready`=1. A transfer is `in_valid && in_ready`.
  - Each transfer writes the encoded word at the pointer, then the pointer and `word_count` increment.
  - A transfer with `in_last`=1 → DONE.
  - A transfer at pointer = 2^ADDR_W−1 without `in_last` → DONE and sets `err_code[1]`. The pointer never wraps.
- DONE: `done`=1, `in_ready`=0. `start` → LOAD (new session, flags cleared).
- `start` is ignored while in LOAD.
- Range checks:
  - I: −512..511.
  - L: −2048..2047.
  - J: 0..511.
  - R: no check.
  - On violation the word is still written with the low field bits, and `err_code[0]` is set (sticky).

## Timing
- Reset values: state IDLE, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `done`=0, `err_code`=0, `word_count`=0.
- Asserting `rst_n` mid-session aborts the session immediately and asynchronously. No further write is issued.
- Write latency is 1 cycle. A transfer at edge N drives `imem_we`=1 with addr/data for the cycle after edge N. The write commits at edge N+1.
- Throughput is one instruction per cycle in LOAD.
- `imem_we` is low whenever no transfer occurred in the previous cycle.
- `in_ready` and `done` are registered from state. `in_ready` falls in the cycle after the terminating transfer.
- `done` rises together with the final `imem_we` pulse.
- `word_count` and the `err_code` updates become visible with the corresponding write.

## Structure
- Shared package `isa_pkg` holds:
  - width constants: opcode 6, register address 2, small immediate 10, big immediate 12, jump 9;
  - field bit positions;
  - format enum (FMT_R/I/L/J);
  - state enum.
- The decoder uses the same constants.
- Sub-module `instr_pack`: purely combinational field packer plus range checker. It outputs the word and a range-error bit. The top level holds the FSM, pointer, counters and output registers.

## Test plan
- `start`, `base_addr`=0x103. Then send fmt L op 0x3F ra=2 imm=10; fmt R op 0 ra=0 rb=0 rc=1; fmt I op 0x10 ra=1 rb=1 imm=1 (last). Required: writes 0xFE00A@0x103, 0x00100@0x104, 0x41401@0x105 on consecutive cycles; `done`=1; `word_count`=3; `err_code`=0.
- fmt I op 0x26 ra=1 rb=2 imm=3 → 0x99803. fmt J op 0x30 imm=0x103 → 0xC2060. fmt I op 0x2C ra=3 rb=0 imm=0 → 0xB3000.
- fmt I imm=512 → word carries imm[9:0]=0x200; `err_code`=01, held until the next `start`. fmt J imm=−1 also sets bit0.
- `base_addr`=510, three valid words with no last, `in_valid` held high. Required: writes at 510 and 511 only; `in_ready` low afterwards; `done`=1; `err_code`=10; `word_count`=2.
- `in_valid` toggling 1,0,1. Required: no `imem_we` pulse in the cycle following a 0; addresses still consecutive.
- `rst_n` low during LOAD with `in_valid`=1. Required: `imem_we` drops without waiting for a clock; after release, state is IDLE with all outputs at reset values; `start` works normally afterwards.
